// File: rtl/riscv16_ctrl_fsm.sv
// riscv16_ctrl_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes, TRAP and retire counter
// Ports: clk, rst_n (async active-low); opcode, zero, imem_ack, dmem_ack in;
//        imem_req, ir_write, pc_write, pc_src, alu_op, alu_src, reg_dst,
//        dmem_req, dmem_we, mem_to_reg, reg_write, illegal, retired out.
module riscv16_ctrl_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             reg_dst,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5;
  logic [2:0] state, state_nx;
  logic [3:0] op_q;
  logic d_ill, d_jmp, q_lw, q_sw, q_mem, q_br, taken, retire;
  logic in_f, in_d, in_e, in_m, in_w, in_t;
  // DECODE acts on the live opcode; every later state uses the latched op_q
  assign d_ill = opcode == 4'b1010 || opcode >= 4'b1110;
  assign d_jmp = opcode == 4'b1101;
  assign q_lw  = op_q == 4'b0000;
  assign q_sw  = op_q == 4'b0001;
  assign q_mem = q_lw | q_sw;
  assign q_br  = op_q == 4'b1011 || op_q == 4'b1100;
  assign taken = (op_q == 4'b1011 && zero) || (op_q == 4'b1100 && !zero);
  always_comb begin
    state_nx = state == S_FETCH  ? (imem_ack ? S_DECODE : S_FETCH) :
               state == S_DECODE ? (d_ill ? S_TRAP : d_jmp ? S_FETCH : S_EXEC) :
               state == S_EXEC   ? (q_mem ? S_MEM : q_br ? S_FETCH : S_WB) :
               state == S_MEM    ? (dmem_ack ? (q_sw ? S_FETCH : S_WB) : S_MEM) :
               state == S_WB     ? S_FETCH : S_TRAP;
  end
  // an instruction retires on the cycle its final state is left
  assign retire = (state == S_DECODE && d_jmp) || (state == S_EXEC && q_br) ||
                  (state == S_MEM && dmem_ack && q_sw) || state == S_WB;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      op_q    <= 4'b0000;
      retired <= '0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) op_q <= opcode;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end
  // state qualifiers are gated by rst_n so every output is low while reset is held
  assign in_f = rst_n && state == S_FETCH;
  assign in_d = rst_n && state == S_DECODE;
  assign in_e = rst_n && state == S_EXEC;
  assign in_m = rst_n && state == S_MEM;
  assign in_w = rst_n && state == S_WB;
  assign in_t = rst_n && state == S_TRAP;
  assign imem_req   = in_f;
  assign ir_write   = in_f && imem_ack;
  assign pc_write   = (in_f && imem_ack) || (in_d && d_jmp) || (in_e && taken);
  assign pc_src     = in_d && d_jmp ? 2'b10 : in_e && taken ? 2'b01 : 2'b00;
  assign alu_op     = in_e && q_mem ? 2'b10 : in_e && q_br ? 2'b01 : 2'b00;
  assign alu_src    = in_e && q_mem;
  assign reg_dst    = in_w && !q_lw;
  assign dmem_req   = in_m;
  assign dmem_we    = in_m && q_sw;
  assign mem_to_reg = in_w && q_lw;
  assign reg_write  = in_w;
  assign illegal    = in_t;
endmodule
